dlfloat_mac_seq: RTL

DLFLOAT_MAC_SEQ -- requirements
Module: dlfloat_mac_seq

---
 rtl/dlfloat_mac_seq_pkg.sv | 16 +
 rtl/dlfloat_drain_timer.sv | 34 +++
 rtl/dlfloat_mac_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dlfloat_mac_seq_pkg.sv
// Shared types and constants for the DLFloat dot-product sequencer.
package dlfloat_mac_seq_pkg;

  localparam int DLF_W       = 16;
  localparam int MAC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_DRAIN,
    ST_SEND_LO,
    ST_SEND_HI
  } state_e;

endpackage

// File: rtl/dlfloat_drain_timer.sv
// Loadable down-counter; expire_o is high during the last counted cycle,
// so the edge that ends that cycle is exactly load_val_i edges after the load.
module dlfloat_drain_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/dlfloat_mac_seq.sv
// Sequences operand pairs into an external DLFloat MAC and streams the
// 16-bit accumulated result out as two bytes, low byte first.
module dlfloat_mac_seq
  import dlfloat_mac_seq_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             in_valid_i,
  input  logic [DLF_W-1:0] in_data_i,
  output logic             in_ready_o,
  output logic [DLF_W-1:0] mac_a_o,
  output logic [DLF_W-1:0] mac_b_o,
  output logic             mac_clr_o,
  input  logic [DLF_W-1:0] mac_acc_i,
  output logic             out_valid_o,
  output logic [7:0]       out_byte_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int TMR_W = $clog2(MAC_LAT + 2);
  localparam logic [TMR_W-1:0] DRAIN_CYC = TMR_W'(MAC_LAT + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DLF_W-1:0] ahold_q, ahold_d;
  logic [DLF_W-1:0] result_q, result_d;
  logic [DLF_W-1:0] mac_a_q, mac_a_d;
  logic [DLF_W-1:0] mac_b_q, mac_b_d;
  logic             tmr_load;
  logic             tmr_expire;

  dlfloat_drain_timer #(
    .W(TMR_W)
  ) u_drain_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (DRAIN_CYC),
    .expire_o   (tmr_expire)
  );

  // Operand registers default to zero so non-issue cycles add a zero product.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ahold_d   = ahold_q;
    result_d  = result_q;
    mac_a_d   = '0;
    mac_b_d   = '0;
    mac_clr_o = 1'b0;
    tmr_load  = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d     = cfg_len_i;
          mac_clr_o = 1'b1;
          if (cfg_len_i != '0) begin
            state_d = ST_LOAD_A;
          end else begin
            state_d  = ST_DRAIN;
            tmr_load = 1'b1;
          end
        end
      end
      ST_LOAD_A: begin
        if (in_valid_i) begin
          ahold_d = in_data_i;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (in_valid_i) begin
          mac_a_d = ahold_q;
          mac_b_d = in_data_i;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end
          if (cnt_q <= LEN_W'(1)) begin
            state_d  = ST_DRAIN;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_expire) begin
          result_d = mac_acc_i;
          state_d  = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (out_ready_i) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (out_ready_i) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ahold_q  <= '0;
      result_q <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ahold_q  <= ahold_d;
      result_q <= result_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
    end
  end

  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign in_ready_o  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign out_valid_o = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_byte_o  = (state_q == ST_SEND_LO) ? result_q[7:0]  :
                       (state_q == ST_SEND_HI) ? result_q[15:8] : 8'h00;

endmodule
